// File: rtl/jam_pkg.sv
// rtl/jam_pkg.sv - shared constants, state enum and helpers for the job-assignment cost scheduler
package jam_pkg;

    localparam int N_WORKER = 8;
    localparam int IDX_W    = 3;
    localparam int COST_W   = 7;
    localparam int SUM_W    = 10;
    localparam int CNT_W    = 16;
    localparam int PERM_W   = N_WORKER * IDX_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORKER - 1);
    localparam logic [SUM_W-1:0] MIN_INIT = '1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_UPDATE,
        ST_DONE
    } jam_sched_state_t;

    // Job assigned to worker w in a packed permutation.
    function automatic logic [IDX_W-1:0] job_of(input logic [PERM_W-1:0] p,
                                                 input logic [IDX_W-1:0]  w);
        return p[w*IDX_W +: IDX_W];
    endfunction

endpackage

// File: rtl/jam_min_tracker.sv
// rtl/jam_min_tracker.sv - running minimum cost and saturating count of candidates achieving it
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   init          reload min to all-ones and count to 0 (first candidate of a search)
//   update        compare acc against the current minimum
//   acc           total cost of the candidate just accumulated
//   min_cost      registered running minimum
//   match_count   registered number of candidates equal to min_cost
module jam_min_tracker
    import jam_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             init,
    input  logic             update,
    input  logic [SUM_W-1:0] acc,
    output logic [SUM_W-1:0] min_cost,
    output logic [CNT_W-1:0] match_count
);

    always_ff @(posedge CLK) begin
        if (RST) begin
            min_cost    <= MIN_INIT;
            match_count <= '0;
        end else if (init) begin
            min_cost    <= MIN_INIT;
            match_count <= '0;
        end else if (update) begin
            if (acc < min_cost) begin
                min_cost    <= acc;
                match_count <= CNT_W'(1);
            end else if (acc == min_cost && match_count != CNT_MAX) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/jam_cost_sched.sv
// rtl/jam_cost_sched.sv - sequences cost ROM reads per candidate assignment and tracks min total cost
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   perm_valid/perm_ready    candidate handshake; perm holds job of worker w at perm[3w+2:3w]
//   perm_last                marks the final candidate of a search
//   W, J                     cost ROM worker/job address (zero outside FETCH)
//   Cost                     ROM data, valid one cycle after W/J
//   MinCost, MatchCount      running/final minimum and number of candidates achieving it
//   Valid                    one-cycle pulse when the search result is final
//   busy                     scheduler not idle
module jam_cost_sched
    import jam_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              perm_valid,
    output logic              perm_ready,
    input  logic [PERM_W-1:0] perm,
    input  logic              perm_last,
    output logic [IDX_W-1:0]  W,
    output logic [IDX_W-1:0]  J,
    input  logic [COST_W-1:0] Cost,
    output logic [SUM_W-1:0]  MinCost,
    output logic [CNT_W-1:0]  MatchCount,
    output logic              Valid,
    output logic              busy
);

    jam_sched_state_t  state_q, state_d;
    logic [PERM_W-1:0] perm_q;
    logic              last_q;
    logic [IDX_W-1:0]  idx_q;      // doubles as the W address register
    logic [IDX_W-1:0]  job_q;
    logic              dv_q;       // a ROM read was issued last cycle, Cost is valid now
    logic [SUM_W-1:0]  acc_q;
    logic              fresh_q;    // next accept starts a new search
    logic              valid_q;
    logic              accept;
    logic              trk_init;
    logic              trk_update;

    assign perm_ready = (state_q == ST_IDLE) && !RST;
    assign busy       = (state_q != ST_IDLE);
    assign accept     = perm_valid && perm_ready;
    assign W          = idx_q;
    assign J          = job_q;
    assign Valid      = valid_q;

    always_comb begin
        state_d    = state_q;
        trk_init   = 1'b0;
        trk_update = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_FETCH;
                    trk_init = fresh_q;
                end
            end
            ST_FETCH: begin
                if (idx_q == LAST_IDX) state_d = ST_DRAIN;
            end
            ST_DRAIN:  state_d = ST_UPDATE;
            ST_UPDATE: begin
                trk_update = 1'b1;
                state_d    = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            perm_q  <= '0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            job_q   <= '0;
            dv_q    <= 1'b0;
            acc_q   <= '0;
            fresh_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            dv_q    <= (state_q == ST_FETCH);
            valid_q <= (state_d == ST_DONE);

            // accept and dv never coincide: dv is only high after a FETCH cycle.
            if (accept) begin
                perm_q  <= perm;
                last_q  <= perm_last;
                acc_q   <= '0;
                idx_q   <= '0;
                job_q   <= job_of(perm, '0);
                fresh_q <= 1'b0;
            end else if (dv_q) begin
                acc_q <= acc_q + {{(SUM_W-COST_W){1'b0}}, Cost};
            end

            if (state_q == ST_FETCH) begin
                if (idx_q == LAST_IDX) begin
                    idx_q <= '0;
                    job_q <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                    job_q <= job_of(perm_q, idx_q + IDX_W'(1));
                end
            end

            if (state_q == ST_DONE) fresh_q <= 1'b1;
        end
    end

    jam_min_tracker u_min_tracker (
        .CLK         (CLK),
        .RST         (RST),
        .init        (trk_init),
        .update      (trk_update),
        .acc         (acc_q),
        .min_cost    (MinCost),
        .match_count (MatchCount)
    );

endmodule

// File: tb/tb_jam_cost_sched.sv
// tb/tb_jam_cost_sched.sv - randomized self-checking bench with behavioural min-cost model
module tb_jam_cost_sched;

    logic        CLK = 1'b0;
    logic        RST;
    logic        perm_valid;
    logic        perm_ready;
    logic [23:0] perm;
    logic        perm_last;
    logic [2:0]  W;
    logic [2:0]  J;
    logic [6:0]  Cost;
    logic [9:0]  MinCost;
    logic [15:0] MatchCount;
    logic        Valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [6:0] rom [8][8];

    // behavioural model of the search result
    int m_min;
    int m_cnt;
    bit m_fresh;

    always #5 CLK = ~CLK;

    jam_cost_sched dut (
        .CLK        (CLK),
        .RST        (RST),
        .perm_valid (perm_valid),
        .perm_ready (perm_ready),
        .perm       (perm),
        .perm_last  (perm_last),
        .W          (W),
        .J          (J),
        .Cost       (Cost),
        .MinCost    (MinCost),
        .MatchCount (MatchCount),
        .Valid      (Valid),
        .busy       (busy)
    );

    // cost ROM: one cycle read latency
    always @(posedge CLK) Cost <= rom[W][J];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_rom(input int mode);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                case (mode)
                    0: rom[w][j] = 7'(w + j);
                    1: rom[w][j] = (w == j) ? 7'd0 : 7'd127;
                    2: rom[w][j] = 7'd127;
                    3: rom[w][j] = 7'd5;
                    4: rom[w][j] = 7'(j + 4);
                    default: rom[w][j] = 7'($urandom_range(127, 0));
                endcase
    endtask

    function automatic logic [23:0] ident_perm();
        logic [23:0] p;
        for (int w = 0; w < 8; w++) p[3*w +: 3] = 3'(w);
        return p;
    endfunction

    function automatic logic [23:0] rev_perm();
        logic [23:0] p;
        for (int w = 0; w < 8; w++) p[3*w +: 3] = 3'(7 - w);
        return p;
    endfunction

    function automatic logic [23:0] rand_perm();
        int a[8];
        int k;
        int t;
        logic [23:0] p;
        for (int i = 0; i < 8; i++) a[i] = i;
        for (int i = 7; i > 0; i--) begin
            k = int'($urandom_range(i, 0));
            t = a[i]; a[i] = a[k]; a[k] = t;
        end
        for (int i = 0; i < 8; i++) p[3*i +: 3] = 3'(a[i]);
        return p;
    endfunction

    function automatic int perm_cost(input logic [23:0] p);
        int s = 0;
        for (int w = 0; w < 8; w++) s += int'(rom[w][p[3*w +: 3]]);
        return s;
    endfunction

    // Offers one candidate at a negedge, keeps perm_valid asserted through the
    // busy window and checks addresses, handshake, latency and the result.
    task automatic run_cand(input logic [23:0] p, input logic last);
        int n = 0;
        int s;
        while (!perm_ready && n < 20) begin
            @(negedge CLK);
            n++;
        end
        if (!perm_ready) begin
            check("ready_wait", 32'(perm_ready), 32'd1);
            return;
        end
        perm       = p;
        perm_last  = last;
        perm_valid = 1'b1;

        if (m_fresh) begin
            m_min   = 1023;
            m_cnt   = 0;
            m_fresh = 1'b0;
        end
        s = perm_cost(p);
        if (s < m_min) begin
            m_min = s;
            m_cnt = 1;
        end else if (s == m_min && m_cnt < 65535) begin
            m_cnt++;
        end

        for (int k = 1; k <= 10; k++) begin
            @(negedge CLK);
            check("ready_low", 32'(perm_ready), 32'd0);
            check("busy_high", 32'(busy), 32'd1);
            check("valid_early", 32'(Valid), 32'd0);
            if (k <= 8) begin
                check("w_seq", 32'(W), 32'(k - 1));
                check("j_seq", 32'(J), 32'(p[3*(k-1) +: 3]));
            end else begin
                check("w_idle", 32'(W), 32'd0);
                check("j_idle", 32'(J), 32'd0);
            end
        end
        perm_valid = 1'b0;

        @(negedge CLK);
        check("ready_after", 32'(perm_ready), 32'(!last));
        check("valid_pulse", 32'(Valid), 32'(last));
        check("min_cost", 32'(MinCost), 32'(m_min));
        check("match_count", 32'(MatchCount), 32'(m_cnt));
        if (last) begin
            m_fresh = 1'b1;
            @(negedge CLK);
            check("ready_done", 32'(perm_ready), 32'd1);
            check("valid_once", 32'(Valid), 32'd0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [23:0] p;
        logic [23:0] prev;
        int ncand;

        RST        = 1'b1;
        perm_valid = 1'b0;
        perm       = '0;
        perm_last  = 1'b0;
        m_min      = 1023;
        m_cnt      = 0;
        m_fresh    = 1'b1;
        set_rom(0);

        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(perm_ready), 32'd0);
        check("rst_w", 32'(W), 32'd0);
        check("rst_j", 32'(J), 32'd0);
        check("rst_min", 32'(MinCost), 32'd1023);
        check("rst_cnt", 32'(MatchCount), 32'd0);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("ready_release", 32'(perm_ready), 32'd1);

        // w+j ROM: identity and reversed both cost 56
        set_rom(0);
        run_cand(ident_perm(), 1'b0);
        run_cand(rev_perm(), 1'b1);

        // diagonal ROM: identity 0, swap of workers 0/1 costs 254
        set_rom(1);
        p = ident_perm();
        run_cand(p, 1'b0);
        p[2:0] = 3'd1;
        p[5:3] = 3'd0;
        run_cand(p, 1'b1);

        // all-127 ROM: maximum total 1016
        set_rom(2);
        run_cand(rand_perm(), 1'b1);

        // reset during FETCH cycle 4 discards the candidate and the partial search
        set_rom(5);
        run_cand(rand_perm(), 1'b0);
        perm       = rand_perm();
        perm_last  = 1'b1;
        perm_valid = 1'b1;
        repeat (4) @(negedge CLK);
        check("mid_w", 32'(W), 32'd3);
        RST = 1'b1;
        @(negedge CLK);
        perm_valid = 1'b0;
        check("mrst_ready", 32'(perm_ready), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_w", 32'(W), 32'd0);
        check("mrst_min", 32'(MinCost), 32'd1023);
        check("mrst_cnt", 32'(MatchCount), 32'd0);
        check("mrst_valid", 32'(Valid), 32'd0);
        RST     = 1'b0;
        m_fresh = 1'b1;
        @(negedge CLK);
        check("mrst_valid2", 32'(Valid), 32'd0);
        run_cand(rand_perm(), 1'b0);
        run_cand(rand_perm(), 1'b1);

        // back-to-back single-candidate searches: 40 then 60
        set_rom(3);
        run_cand(rand_perm(), 1'b1);
        set_rom(4);
        run_cand(rand_perm(), 1'b1);

        // randomized searches, with repeated candidates to produce ties
        for (int s = 0; s < 12; s++) begin
            set_rom(5);
            ncand = int'($urandom_range(4, 1));
            prev  = rand_perm();
            for (int c = 0; c < ncand; c++) begin
                p = ($urandom_range(2, 0) == 0) ? prev : rand_perm();
                run_cand(p, 1'(c == ncand - 1));
                prev = p;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
